// File: rtl/json_rx_pkg.sv
// Shared definitions for the robot-base JSON serial link: parser states, key ids, ASCII codes.
package json_rx_pkg;

  localparam int unsigned VAL_W = 16;

  typedef enum logic [3:0] {
    P_IDLE, P_KEY_Q, P_KEY, P_KEY_END, P_COLON,
    P_VAL_SIGN, P_INT, P_FRAC, P_EOL, P_DRAIN
  } parse_state_e;

  typedef enum logic [1:0] {KEY_T, KEY_L, KEY_R, KEY_OTHER} key_id_e;

  localparam logic [7:0] ASCII_LBRACE = 8'h7B;
  localparam logic [7:0] ASCII_RBRACE = 8'h7D;
  localparam logic [7:0] ASCII_QUOTE  = 8'h22;
  localparam logic [7:0] ASCII_COLON  = 8'h3A;
  localparam logic [7:0] ASCII_COMMA  = 8'h2C;
  localparam logic [7:0] ASCII_PERIOD = 8'h2E;
  localparam logic [7:0] ASCII_MINUS  = 8'h2D;
  localparam logic [7:0] ASCII_DIGIT0 = 8'h30;
  localparam logic [7:0] ASCII_DIGIT9 = 8'h39;
  localparam logic [7:0] ASCII_LF     = 8'h0A;
  localparam logic [7:0] ASCII_CR     = 8'h0D;
  localparam logic [7:0] ASCII_SPACE  = 8'h20;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= ASCII_DIGIT0) && (c <= ASCII_DIGIT9);
  endfunction

  function automatic logic is_letter(input logic [7:0] c);
    return ((c >= 8'h41) && (c <= 8'h5A)) || ((c >= 8'h61) && (c <= 8'h7A));
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1-style UART receiver: 2-FF synchroniser, falling-edge start detect, mid-bit sampling.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned BITS_N       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              uart_in,
  output logic [BITS_N-1:0] data_rx,
  output logic              rx_valid,
  output logic              rx_err
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned BIT_W = $clog2(BITS_N + 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  rx_state_e         state_q, state_d;
  logic [2:0]        sync_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [BITS_N-1:0] shreg_q, shreg_d, data_q, data_d;
  logic              valid_q, valid_d, err_q, err_d;
  logic              line_c, fall_c;

  assign line_c   = sync_q[1];
  // Edge-triggered start so a line held low after a bad stop bit cannot retrigger.
  assign fall_c   = sync_q[2] & ~sync_q[1];
  assign data_rx  = data_q;
  assign rx_valid = valid_q;
  assign rx_err   = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RX_IDLE;
      sync_q  <= 3'b111;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[1:0], uart_in};
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    bit_d   = bit_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (fall_c) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = line_c ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL) begin
          cnt_d   = '0;
          shreg_d = {line_c, shreg_q[BITS_N-1:1]};
          if (bit_q == BIT_W'(BITS_N - 1)) state_d = RX_STOP;
          else bit_d = bit_q + BIT_W'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL) begin
          state_d = RX_IDLE;
          if (line_c) begin
            valid_d = 1'b1;
            data_d  = shreg_q;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/json_feedback_receiver.sv
// Receive side of the base JSON link: parses {"T":n,"L":x.y,"R":x.y}\n frames into registered fields.
// Optional idle-gap abort of partial frames is enabled by defining JSON_RX_TIMEOUT_EN.
module json_feedback_receiver
  import json_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT    = 50_000_000 / 115_200,
  parameter int unsigned BITS_N          = 8,
  parameter int unsigned MAX_FRAME_BYTES = 64
`ifdef JSON_RX_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CLKS  = 500_000
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             uart_in,
  output logic             frame_valid,
  output logic [VAL_W-1:0] t_code,
  output logic [VAL_W-1:0] l_val,
  output logic [VAL_W-1:0] r_val,
  output logic             frame_error,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(MAX_FRAME_BYTES + 2);
  localparam int unsigned ACC_W = VAL_W + 4;
  localparam logic [ACC_W-1:0] U_MAX = ACC_W'(16'hFFFF);
  localparam logic [ACC_W-1:0] S_MAX = ACC_W'(16'h7FFF);

  logic [1:0]        rst_sync_q;
  logic              rst_int_n;
  logic [BITS_N-1:0] rx_data;
  logic              rx_valid, rx_err;

  parse_state_e     state_q, state_d;
  key_id_e          key_q, key_d;
  logic             neg_q, neg_d, frac_seen_q, frac_seen_d;
  logic [VAL_W-1:0] acc_q, acc_d;
  logic [3:0]       frac_q, frac_d;
  logic [VAL_W-1:0] t_p_q, t_p_d, l_p_q, l_p_d, r_p_q, r_p_d;
  logic             t_seen_q, t_seen_d, l_seen_q, l_seen_d, r_seen_q, r_seen_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [VAL_W-1:0] t_code_q, t_code_d, l_val_q, l_val_d, r_val_q, r_val_d;
  logic             fv_q, fv_d, fe_q, fe_d, busy_q, busy_d;
  logic             err_c, commit_c;
  logic [7:0]       byte_c;
  logic [3:0]       digit_c;
  logic [ACC_W-1:0] acc_mul_c, mag_c;
  logic [VAL_W-1:0] acc_sat_c, mag_sat_c, sval_c;

`ifdef JSON_RX_TIMEOUT_EN
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CLKS + 1);
  logic [TMR_W-1:0] tmr_q, tmr_d;
`endif

  // Reset asserts asynchronously and releases two clocks later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT), .BITS_N(BITS_N)) u_uart_rx (
    .clk     (clk),
    .rst_n   (rst_int_n),
    .uart_in (uart_in),
    .data_rx (rx_data),
    .rx_valid(rx_valid),
    .rx_err  (rx_err)
  );

  // Saturating decimal accumulate and signed tenths value for the commit path.
  always_comb begin
    byte_c    = 8'(rx_data);
    digit_c   = 4'(byte_c - ASCII_DIGIT0);
    acc_mul_c = ACC_W'(acc_q) * ACC_W'(10) + ACC_W'(digit_c);
    acc_sat_c = (acc_mul_c > U_MAX) ? 16'hFFFF : acc_mul_c[VAL_W-1:0];
    mag_c     = ACC_W'(acc_q) * ACC_W'(10) + ACC_W'(frac_q);
    mag_sat_c = (mag_c > S_MAX) ? 16'h7FFF : mag_c[VAL_W-1:0];
    sval_c    = neg_q ? (VAL_W'(0) - mag_sat_c) : mag_sat_c;
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q <= P_IDLE;   key_q <= KEY_OTHER;
      neg_q <= 1'b0;       frac_seen_q <= 1'b0;
      acc_q <= '0;         frac_q <= '0;
      t_p_q <= '0;         l_p_q <= '0;        r_p_q <= '0;
      t_seen_q <= 1'b0;    l_seen_q <= 1'b0;   r_seen_q <= 1'b0;
      cnt_q <= '0;
      t_code_q <= '0;      l_val_q <= '0;      r_val_q <= '0;
      fv_q <= 1'b0;        fe_q <= 1'b0;       busy_q <= 1'b0;
`ifdef JSON_RX_TIMEOUT_EN
      tmr_q <= '0;
`endif
    end else begin
      state_q <= state_d;  key_q <= key_d;
      neg_q <= neg_d;      frac_seen_q <= frac_seen_d;
      acc_q <= acc_d;      frac_q <= frac_d;
      t_p_q <= t_p_d;      l_p_q <= l_p_d;     r_p_q <= r_p_d;
      t_seen_q <= t_seen_d; l_seen_q <= l_seen_d; r_seen_q <= r_seen_d;
      cnt_q <= cnt_d;
      t_code_q <= t_code_d; l_val_q <= l_val_d; r_val_q <= r_val_d;
      fv_q <= fv_d;        fe_q <= fe_d;       busy_q <= busy_d;
`ifdef JSON_RX_TIMEOUT_EN
      tmr_q <= tmr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;   key_d = key_q;
    neg_d = neg_q;       frac_seen_d = frac_seen_q;
    acc_d = acc_q;       frac_d = frac_q;
    t_p_d = t_p_q;       l_p_d = l_p_q;        r_p_d = r_p_q;
    t_seen_d = t_seen_q; l_seen_d = l_seen_q;  r_seen_d = r_seen_q;
    cnt_d = cnt_q;
    t_code_d = t_code_q; l_val_d = l_val_q;    r_val_d = r_val_q;
    fv_d = 1'b0;         fe_d = 1'b0;
    err_c = 1'b0;        commit_c = 1'b0;
    case (state_q)
      P_IDLE: begin
        if (rx_valid && byte_c == ASCII_LBRACE) begin
          state_d = P_KEY_Q; cnt_d = '0;
          t_seen_d = 1'b0;   l_seen_d = 1'b0; r_seen_d = 1'b0;
        end
      end
      P_DRAIN: if (rx_valid && byte_c == ASCII_LF) state_d = P_IDLE;
      default: begin
        if (rx_valid || rx_err) cnt_d = cnt_q + CNT_W'(1);
        if (rx_err || (rx_valid && cnt_q == CNT_W'(MAX_FRAME_BYTES))) begin
          err_c = 1'b1;
        end else if (rx_valid && !(byte_c == ASCII_SPACE && !(state_q inside {P_INT, P_FRAC}))) begin
          case (state_q)
            P_KEY_Q:   if (byte_c == ASCII_QUOTE) state_d = P_KEY; else err_c = 1'b1;
            P_KEY: begin
              if (is_letter(byte_c)) begin
                state_d = P_KEY_END;
                key_d = (byte_c == 8'h54) ? KEY_T : (byte_c == 8'h4C) ? KEY_L :
                        (byte_c == 8'h52) ? KEY_R : KEY_OTHER;
              end else err_c = 1'b1;
            end
            P_KEY_END: if (byte_c == ASCII_QUOTE) state_d = P_COLON; else err_c = 1'b1;
            P_COLON: begin
              if (byte_c == ASCII_COLON) begin
                state_d = P_VAL_SIGN; neg_d = 1'b0; acc_d = '0;
                frac_d = '0;          frac_seen_d = 1'b0;
              end else err_c = 1'b1;
            end
            P_VAL_SIGN: begin
              if (byte_c == ASCII_MINUS && !neg_q) neg_d = 1'b1;
              else if (is_digit(byte_c)) begin
                acc_d = VAL_W'(digit_c); state_d = P_INT;
              end else err_c = 1'b1;
            end
            P_INT, P_FRAC: begin
              if (is_digit(byte_c)) begin
                if (state_q == P_INT) acc_d = acc_sat_c;
                else if (!frac_seen_q) begin
                  frac_d = digit_c; frac_seen_d = 1'b1;
                end
              end else if (byte_c == ASCII_PERIOD && state_q == P_INT) state_d = P_FRAC;
              else if (byte_c == ASCII_COMMA)  begin commit_c = 1'b1; state_d = P_KEY_Q; end
              else if (byte_c == ASCII_RBRACE) begin commit_c = 1'b1; state_d = P_EOL; end
              else err_c = 1'b1;
            end
            P_EOL: begin
              if (byte_c == ASCII_LF && t_seen_q) begin
                fv_d = 1'b1;  state_d = P_IDLE;  t_code_d = t_p_q;
                if (l_seen_q) l_val_d = l_p_q;
                if (r_seen_q) r_val_d = r_p_q;
              end else if (byte_c != ASCII_CR) err_c = 1'b1;
            end
            default: err_c = 1'b1;
          endcase
        end
      end
    endcase
    if (commit_c) begin
      case (key_q)
        KEY_T:   begin t_p_d = acc_q;  t_seen_d = 1'b1; end
        KEY_L:   begin l_p_d = sval_c; l_seen_d = 1'b1; end
        KEY_R:   begin r_p_d = sval_c; r_seen_d = 1'b1; end
        default: ;
      endcase
    end
    // A terminating LF that is itself the offending byte ends the frame outright.
    if (err_c) begin
      fe_d    = 1'b1;
      state_d = (rx_valid && byte_c == ASCII_LF) ? P_IDLE : P_DRAIN;
    end
`ifdef JSON_RX_TIMEOUT_EN
    tmr_d = tmr_q + TMR_W'(1);
    if (state_q == P_IDLE || rx_valid || rx_err) tmr_d = '0;
    else if (tmr_q == TMR_W'(TIMEOUT_CLKS - 1)) begin
      tmr_d   = '0;
      fe_d    = (state_q != P_DRAIN);
      state_d = P_IDLE;
    end
`endif
    busy_d = !(state_d inside {P_IDLE, P_DRAIN});
  end

  assign frame_valid = fv_q;
  assign frame_error = fe_q;
  assign busy        = busy_q;
  assign t_code      = t_code_q;
  assign l_val       = l_val_q;
  assign r_val       = r_val_q;

endmodule

// File: tb/tb_json_feedback_receiver.sv
// Scoreboard bench for json_feedback_receiver: expected frames queued at send, checked on frame_valid.
module tb_json_feedback_receiver;

  localparam int unsigned CPB     = 8;
  localparam int unsigned TO_CLKS = 2000;

  typedef struct {
    logic [15:0] t;
    logic [15:0] l;
    logic [15:0] r;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        uart_in = 1'b1;
  logic        frame_valid, frame_error, busy;
  logic [15:0] t_code, l_val, r_val;

  frame_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int err_cnt  = 0;
  int fv_cnt   = 0;

  json_feedback_receiver #(
    .CLKS_PER_BIT(CPB), .BITS_N(8), .MAX_FRAME_BYTES(64)
`ifdef JSON_RX_TIMEOUT_EN
    , .TIMEOUT_CLKS(TO_CLKS)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .uart_in(uart_in),
    .frame_valid(frame_valid), .t_code(t_code), .l_val(l_val), .r_val(r_val),
    .frame_error(frame_error), .busy(busy)
  );

  always #5 clk = ~clk;

  // Scoreboard: pop one expected frame per frame_valid pulse.
  always @(negedge clk) begin
    if (frame_error) err_cnt++;
    if (frame_valid) begin
      frame_t e;
      fv_cnt++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_frame: got t=%0d l=%0d r=%0d, expected no frame", t_code, $signed(l_val), $signed(r_val));
      end else begin
        e = exp_q.pop_front();
        if (t_code !== e.t || l_val !== e.l || r_val !== e.r) begin
          n_fail++;
          $display("FAIL frame_fields: got t=%0d l=%0d r=%0d, expected t=%0d l=%0d r=%0d",
                   t_code, $signed(l_val), $signed(r_val), e.t, $signed(e.l), $signed(e.r));
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    uart_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_in = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_in = stop_ok;
    repeat (CPB) @(negedge clk);
    uart_in = 1'b1;
    if (!stop_ok) repeat (CPB) @(negedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
  endtask

  task automatic send_spaces(input int n);
    for (int i = 0; i < n; i++) send_byte(8'h20, 1'b1);
  endtask

  task automatic push_exp(input int t, input int l, input int r);
    frame_t e;
    e.t = 16'(t); e.l = 16'(l); e.r = 16'(r);
    exp_q.push_back(e);
  endtask

  task automatic settle();
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (t_code !== 16'd0 || l_val !== 16'd0 || r_val !== 16'd0) begin
      n_fail++; $display("FAIL reset_fields: got t=%0d l=%0d r=%0d, expected 0 0 0", t_code, l_val, r_val);
    end
    n_checks++;
    if (frame_valid !== 1'b0 || frame_error !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: got fv=%b fe=%b busy=%b, expected 0 0 0", frame_valid, frame_error, busy);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_basic();
    int e0 = err_cnt;
    push_exp(1001, 5, -5);
    send_byte(8'h7B, 1'b1);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_in_frame: got %b, expected 1", busy); end
    send_str("\"T\":1001,\"L\":0.5,\"R\":-0.5}\n");
    settle();
    n_checks++;
    if (exp_q.size() != 0 || err_cnt != e0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_done: pending=%0d errors=%0d busy=%b, expected 0 0 0", exp_q.size(), err_cnt - e0, busy);
    end
  endtask

  task automatic test_held_and_unknown();
    int e0 = err_cnt;
    push_exp(7, 5, -5);
    send_str("{\"T\":7}\n");
    push_exp(1, -27, -5);
    send_str("{\"T\":1,\"X\":12,\"L\":-2.75}\n");
    settle();
    n_checks++;
    if (exp_q.size() != 0 || err_cnt != e0) begin
      n_fail++; $display("FAIL held_unknown: pending=%0d errors=%0d, expected 0 0", exp_q.size(), err_cnt - e0);
    end
  endtask

  task automatic test_bad_char();
    int e0 = err_cnt;
    int f0 = fv_cnt;
    send_str("{\"T\":1;} \n");
    settle();
    n_checks++;
    if (err_cnt - e0 != 1 || fv_cnt != f0) begin
      n_fail++; $display("FAIL bad_char: errors=%0d frames=%0d, expected 1 0", err_cnt - e0, fv_cnt - f0);
    end
    push_exp(2, -27, 10);
    send_str("{ \"T\": 2,\"R\" :1.0}\r\n");
    settle();
    n_checks++;
    if (exp_q.size() != 0 || err_cnt - e0 != 1) begin
      n_fail++; $display("FAIL bad_char_recover: pending=%0d errors=%0d, expected 0 1", exp_q.size(), err_cnt - e0);
    end
  endtask

  task automatic test_saturation();
    push_exp(65535, 32767, -32767);
    send_str("{\"T\":70000,\"L\":99999,\"R\":-99999.9}\n");
    settle();
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL saturation: pending=%0d, expected 0", exp_q.size()); end
  endtask

  task automatic test_overlong();
    int e0 = err_cnt;
    int f0 = fv_cnt;
    push_exp(3, 32767, -32767);
    send_byte(8'h7B, 1'b1); send_spaces(57); send_str("\"T\":3}\n");
    settle();
    n_checks++;
    if (exp_q.size() != 0 || err_cnt != e0) begin
      n_fail++; $display("FAIL len_64_ok: pending=%0d errors=%0d, expected 0 0", exp_q.size(), err_cnt - e0);
    end
    send_byte(8'h7B, 1'b1); send_spaces(58); send_str("\"T\":3}\n");
    settle();
    n_checks++;
    if (err_cnt - e0 != 1 || fv_cnt - f0 != 1) begin
      n_fail++; $display("FAIL len_65_err: errors=%0d frames=%0d, expected 1 1", err_cnt - e0, fv_cnt - f0);
    end
    send_byte(8'h7B, 1'b1); send_spaces(70); send_str("\n");
    push_exp(4, 32767, -32767);
    send_str("{\"T\":4}\n");
    settle();
    n_checks++;
    if (err_cnt - e0 != 2 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL len_70_err: errors=%0d pending=%0d, expected 2 0", err_cnt - e0, exp_q.size());
    end
  endtask

  task automatic test_missing_t();
    int e0 = err_cnt;
    send_str("{\"L\":1.5}\n");
    settle();
    n_checks++;
    if (err_cnt - e0 != 1 || t_code !== 16'd4 || l_val !== 16'd32767) begin
      n_fail++; $display("FAIL missing_t: errors=%0d t=%0d l=%0d, expected 1 4 32767", err_cnt - e0, t_code, l_val);
    end
    push_exp(8, 32767, -32767);
    send_str("{\"T\":8}\n");
    settle();
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL missing_t_next: pending=%0d, expected 0", exp_q.size()); end
  endtask

  task automatic test_stop_bit();
    int e0 = err_cnt;
    int f0 = fv_cnt;
    send_str("{\"T\":9");
    send_byte(8'h2C, 1'b0);
    send_str("\"L\":1}\n");
    settle();
    n_checks++;
    if (err_cnt - e0 != 1 || fv_cnt != f0 || t_code !== 16'd8) begin
      n_fail++; $display("FAIL stop_bit: errors=%0d frames=%0d t=%0d, expected 1 0 8", err_cnt - e0, fv_cnt - f0, t_code);
    end
  endtask

  task automatic test_reset_mid();
    int e0 = err_cnt;
    int f0 = fv_cnt;
    send_str("{\"T\":5");
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (t_code !== 16'd0 || l_val !== 16'd0 || r_val !== 16'd0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid: got t=%0d l=%0d r=%0d busy=%b, expected 0 0 0 0", t_code, l_val, r_val, busy);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    send_str(",\"L\":2}\n");
    push_exp(6, 0, 0);
    send_str("{\"T\":6}\n");
    settle();
    n_checks++;
    if (err_cnt != e0 || fv_cnt - f0 != 1 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL reset_recover: errors=%0d frames=%0d pending=%0d, expected 0 1 0", err_cnt - e0, fv_cnt - f0, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    push_exp(100, -1, 123);
    push_exp(200, -1, 124);
    send_str("{\"L\":-0.1,\"R\":12.3,\"T\":100}\n{\"T\":200,\"R\":12.4}\n");
    settle();
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL back_to_back: pending=%0d, expected 0", exp_q.size()); end
  endtask

`ifdef JSON_RX_TIMEOUT_EN
  task automatic test_timeout();
    int e0 = err_cnt;
    send_str("{\"T\":1");
    repeat (TO_CLKS + 50) @(negedge clk);
    n_checks++;
    if (err_cnt - e0 != 1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL timeout: errors=%0d busy=%b, expected 1 0", err_cnt - e0, busy);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_held_and_unknown();
    test_bad_char();
    test_saturation();
    test_overlong();
    test_missing_t();
    test_stop_bit();
    test_back_to_back();
    test_reset_mid();
`ifdef JSON_RX_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
